// File: rtl/logic_pkg.sv
// rtl/logic_pkg.sv - op encodings, op type and result-register state for the shared logic unit
package logic_pkg;

  typedef logic [1:0] lop_t;

  localparam lop_t LOP_AND = 2'b00;
  localparam lop_t LOP_OR  = 2'b01;
  localparam lop_t LOP_XOR = 2'b10;
  localparam lop_t LOP_NOR = 2'b11;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/logic_unit.sv
// rtl/logic_unit.sv - combinational 16-bit bitwise logic unit (AND/OR/XOR/NOR)
module logic_unit
  import logic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  lop_t             op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] and_v;
  logic [WIDTH-1:0] or_v;
  logic [WIDTH-1:0] xor_v;
  logic [WIDTH-1:0] nor_v;

  assign and_v = x & y;
  assign or_v  = x | y;
  assign xor_v = x ^ y;
  assign nor_v = ~(x | y);

  always_comb begin
    out = and_v;
    case (op)
      LOP_AND: out = and_v;
      LOP_OR:  out = or_v;
      LOP_XOR: out = xor_v;
      default: out = nor_v;
    endcase
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin arbiter sharing one logic unit; LOGIC_ARB_FLAGS_EN adds rsp_zero/rsp_par
module logic_unit_arbiter
  import logic_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 16,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_x,
  input  logic [WIDTH*NREQ-1:0] req_y,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy
`ifdef LOGIC_ARB_FLAGS_EN
  ,
  output logic                  rsp_zero,
  output logic                  rsp_par
`endif
);

  state_t           state_q;
  state_t           state_d;
  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   grant;
  logic             found;
  logic             can_accept;
  logic             accept;
  lop_t             g_op;
  logic [WIDTH-1:0] g_x;
  logic [WIDTH-1:0] g_y;
  logic [WIDTH-1:0] result;

  // Rotating priority: first valid requester at or after ptr_q, wrapping.
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[(int'(ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        grant = IDW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  assign g_op = req_op[grant*2 +: 2];
  assign g_x  = req_x[grant*WIDTH +: WIDTH];
  assign g_y  = req_y[grant*WIDTH +: WIDTH];

  logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
    .op  (g_op),
    .x   (g_x),
    .y   (g_y),
    .out (result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    can_accept = (state_q == EMPTY) | rsp_ready;
    accept     = found & can_accept & rst_n;
    req_ready  = '0;
    if (accept) req_ready[grant] = 1'b1;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL: begin
        if (accept)         state_d = FULL;
        else if (rsp_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // rsp_data is left untouched when draining to EMPTY so the last result stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_id   <= '0;
      ptr_q    <= '0;
    end else if (accept) begin
      rsp_data <= result;
      rsp_id   <= grant;
      ptr_q    <= (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
    end
  end

`ifdef LOGIC_ARB_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_zero <= 1'b0;
      rsp_par  <= 1'b0;
    end else if (accept) begin
      rsp_zero <= (result == '0);
      rsp_par  <= ^result;
    end
  end
`endif

  assign rsp_valid = (state_q == FULL);
  assign busy      = rsp_valid | (|req_valid);

  for (genvar i = 0; i < NREQ; i++) begin : g_hold_chk
    assert property (@(posedge clk) disable iff (!rst_n)
      (req_valid[i] && !req_ready[i]) |=>
        (req_valid[i] && $stable(req_op[2*i +: 2]) &&
         $stable(req_x[WIDTH*i +: WIDTH]) && $stable(req_y[WIDTH*i +: WIDTH])));
  end

endmodule
